// File: rtl/cnn_ctrl_pkg.sv
// Shared types and default widths for the CNN frame-timing controller.
// The top level uses these constants for every field width.
package cnn_ctrl_pkg;

  localparam int unsigned W_SIZE       = 12;
  localparam int unsigned W_DELAY      = 12;
  localparam int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StHsync,
    StData,
    StDone
  } ctrl_state_e;

  // State that opens a row: HSYNC, or straight into DATA when there is no hsync delay.
  function automatic ctrl_state_e row_entry_state(input logic hsync_zero);
    return hsync_zero ? StData : StHsync;
  endfunction

endpackage

// File: rtl/cnn_ctrl_fsm_if.sv
// Configuration/start inputs and timing outputs of cnn_ctrl_fsm.
// The master side drives the configuration; the slave side is the controller.
interface cnn_ctrl_fsm_if #(
  parameter int unsigned W_SIZE       = cnn_ctrl_pkg::W_SIZE,
  parameter int unsigned W_DELAY      = cnn_ctrl_pkg::W_DELAY,
  parameter int unsigned W_FRAME_SIZE = 2 * W_SIZE + 1
);

  logic [W_SIZE-1:0]       q_width;
  logic [W_SIZE-1:0]       q_height;
  logic [W_DELAY-1:0]      q_vsync_delay;
  logic [W_DELAY-1:0]      q_hsync_delay;
  logic [W_FRAME_SIZE-1:0] q_frame_size;
  logic                    q_start;

  logic                    o_ctrl_vsync_run;
  logic [W_DELAY-1:0]      o_ctrl_vsync_cnt;
  logic                    o_ctrl_hsync_run;
  logic [W_DELAY-1:0]      o_ctrl_hsync_cnt;
  logic                    o_ctrl_data_run;
  logic [W_SIZE-1:0]       o_row;
  logic [W_SIZE-1:0]       o_col;
  logic [W_FRAME_SIZE-1:0] o_data_count;
  logic                    o_end_frame;

  modport master (
    output q_width, q_height, q_vsync_delay, q_hsync_delay, q_frame_size, q_start,
    input  o_ctrl_vsync_run, o_ctrl_vsync_cnt, o_ctrl_hsync_run, o_ctrl_hsync_cnt,
    input  o_ctrl_data_run, o_row, o_col, o_data_count, o_end_frame
  );

  modport slave (
    input  q_width, q_height, q_vsync_delay, q_hsync_delay, q_frame_size, q_start,
    output o_ctrl_vsync_run, o_ctrl_vsync_cnt, o_ctrl_hsync_run, o_ctrl_hsync_cnt,
    output o_ctrl_data_run, o_row, o_col, o_data_count, o_end_frame
  );

endinterface

// File: rtl/cnn_ctrl_counter.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count flag
// that is high while the count equals last_i.
module cnn_ctrl_counter #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/cnn_ctrl_fsm.sv
// Frame-timing controller: VSYNC, then per row HSYNC + DATA, then a one-cycle DONE pulse.
// Define CNN_CTRL_FRAME_LIMIT_EN to also end the frame after q_frame_size pixels.
module cnn_ctrl_fsm
  import cnn_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rstn,
  cnn_ctrl_fsm_if.slave ctrl_io
);

  ctrl_state_e state_q, state_d;

  logic start_prev_q;
  logic trig_q, trig_d;

  logic vsync_run_q, hsync_run_q, data_run_q, end_frame_q;
  logic [W_FRAME_SIZE-1:0] count_q, count_d;

  logic               v_clr, v_en, v_tc;
  logic               h_clr, h_en, h_tc;
  logic               col_clr, col_en, col_tc;
  logic               row_clr, row_en, row_tc;
  logic [W_DELAY-1:0] v_cnt, h_cnt, v_last, h_last;
  logic [W_SIZE-1:0]  col_cnt, row_cnt, col_last, row_last;

  logic v_skip, h_skip, limit_hit, last_pixel;

  assign v_skip   = (ctrl_io.q_vsync_delay == '0);
  assign h_skip   = (ctrl_io.q_hsync_delay == '0);
  assign v_last   = ctrl_io.q_vsync_delay - W_DELAY'(1);
  assign h_last   = ctrl_io.q_hsync_delay - W_DELAY'(1);
  assign col_last = ctrl_io.q_width - W_SIZE'(1);
  assign row_last = ctrl_io.q_height - W_SIZE'(1);

  // Rising edge of q_start, only counted while idle so mid-frame edges are dropped.
  assign trig_d = ctrl_io.q_start & ~start_prev_q & (state_q == StIdle);

`ifdef CNN_CTRL_FRAME_LIMIT_EN
  assign limit_hit = (ctrl_io.q_frame_size != '0) &&
                     (count_q == ctrl_io.q_frame_size - W_FRAME_SIZE'(1));
`else
  logic unused_frame_size;
  assign unused_frame_size = ^ctrl_io.q_frame_size;
  assign limit_hit         = 1'b0;
`endif

  assign last_pixel = (col_tc & row_tc) | limit_hit;

  cnn_ctrl_counter #(
    .Width (W_DELAY)
  ) u_vsync_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (v_clr),
    .en_i   (v_en),
    .last_i (v_last),
    .cnt_o  (v_cnt),
    .tc_o   (v_tc)
  );

  cnn_ctrl_counter #(
    .Width (W_DELAY)
  ) u_hsync_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (h_clr),
    .en_i   (h_en),
    .last_i (h_last),
    .cnt_o  (h_cnt),
    .tc_o   (h_tc)
  );

  cnn_ctrl_counter #(
    .Width (W_SIZE)
  ) u_col_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (col_clr),
    .en_i   (col_en),
    .last_i (col_last),
    .cnt_o  (col_cnt),
    .tc_o   (col_tc)
  );

  cnn_ctrl_counter #(
    .Width (W_SIZE)
  ) u_row_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (row_clr),
    .en_i   (row_en),
    .last_i (row_last),
    .cnt_o  (row_cnt),
    .tc_o   (row_tc)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    v_clr   = 1'b0;
    v_en    = 1'b0;
    h_clr   = 1'b0;
    h_en    = 1'b0;
    col_clr = 1'b0;
    col_en  = 1'b0;
    row_clr = 1'b0;
    row_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        v_clr   = 1'b1;
        h_clr   = 1'b1;
        col_clr = 1'b1;
        row_clr = 1'b1;
        count_d = '0;
        if (trig_q) begin
          state_d = v_skip ? row_entry_state(h_skip) : StVsync;
        end
      end
      StVsync: begin
        v_en = 1'b1;
        if (v_tc) begin
          v_clr   = 1'b1;
          state_d = row_entry_state(h_skip);
        end
      end
      StHsync: begin
        h_en = 1'b1;
        if (h_tc) begin
          h_clr   = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        col_en  = 1'b1;
        count_d = count_q + W_FRAME_SIZE'(1);
        if (last_pixel) begin
          col_clr = 1'b1;
          state_d = StDone;
        end else if (col_tc) begin
          col_clr = 1'b1;
          row_en  = 1'b1;
          state_d = row_entry_state(h_skip);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      trig_q       <= 1'b0;
      count_q      <= '0;
      vsync_run_q  <= 1'b0;
      hsync_run_q  <= 1'b0;
      data_run_q   <= 1'b0;
      end_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= ctrl_io.q_start;
      trig_q       <= trig_d;
      count_q      <= count_d;
      vsync_run_q  <= (state_d == StVsync);
      hsync_run_q  <= (state_d == StHsync);
      data_run_q   <= (state_d == StData);
      end_frame_q  <= (state_d == StDone);
    end
  end

  assign ctrl_io.o_ctrl_vsync_run = vsync_run_q;
  assign ctrl_io.o_ctrl_vsync_cnt = v_cnt;
  assign ctrl_io.o_ctrl_hsync_run = hsync_run_q;
  assign ctrl_io.o_ctrl_hsync_cnt = h_cnt;
  assign ctrl_io.o_ctrl_data_run  = data_run_q;
  assign ctrl_io.o_row            = row_cnt;
  assign ctrl_io.o_col            = col_cnt;
  assign ctrl_io.o_data_count     = count_q;
  assign ctrl_io.o_end_frame      = end_frame_q;

  // Run flags and the end pulse are mutually exclusive phases of one frame.
  a_phase_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0({vsync_run_q, hsync_run_q, data_run_q, end_frame_q}));

  a_flags_track_state: assert property (@(posedge clk) disable iff (!rstn)
    (data_run_q == (state_q == StData)) && (end_frame_q == (state_q == StDone)));

endmodule

// File: tb/tb_cnn_ctrl_fsm.sv
// Bench for cnn_ctrl_fsm: vector table of frame configs plus hand sequences for
// start latency, ignored triggers, back-to-back frames and mid-frame reset.
module tb_cnn_ctrl_fsm;
  import cnn_ctrl_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cnn_ctrl_fsm_if ctrl_if ();

  cnn_ctrl_fsm dut (
    .clk     (clk),
    .rstn    (rstn),
    .ctrl_io (ctrl_if)
  );

  // kind: 0 VSYNC, 1 HSYNC, 2 DATA, 3 DONE
  typedef struct {
    int unsigned kind;
    int unsigned vcnt;
    int unsigned hcnt;
    int unsigned row;
    int unsigned col;
    int unsigned cnt;
  } exp_t;

  typedef struct {
    int unsigned w;
    int unsigned h;
    int unsigned v;
    int unsigned hs;
    int unsigned fs;
    int unsigned hold;
    int unsigned len;
    int unsigned last;
  } vec_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          active_cycles = 0;
  int          end_pulses = 0;
  int unsigned last_cnt = 0;

`ifdef CNN_CTRL_FRAME_LIMIT_EN
  localparam bit LimitOn = 1'b1;
`else
  localparam bit LimitOn = 1'b0;
`endif

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_idle(input string name);
    logic any;
    any = |{ctrl_if.o_ctrl_vsync_run, ctrl_if.o_ctrl_vsync_cnt, ctrl_if.o_ctrl_hsync_run,
            ctrl_if.o_ctrl_hsync_cnt, ctrl_if.o_ctrl_data_run, ctrl_if.o_row, ctrl_if.o_col,
            ctrl_if.o_data_count, ctrl_if.o_end_frame};
    check(name, any, 0);
  endtask

  // Reference frame: one record per active cycle, in order.
  task automatic push_frame(input int unsigned w, input int unsigned h, input int unsigned v,
                            input int unsigned hs, input int unsigned fs);
    exp_t        e;
    int unsigned n;
    bit          done;
    for (int i = 0; i < int'(v); i++) begin
      e = '{0, i, 0, 0, 0, 0};
      sb_q.push_back(e);
    end
    n    = 0;
    done = 1'b0;
    for (int r = 0; r < int'(h) && !done; r++) begin
      for (int j = 0; j < int'(hs); j++) begin
        e = '{1, 0, j, r, 0, n};
        sb_q.push_back(e);
      end
      for (int c = 0; c < int'(w) && !done; c++) begin
        e = '{2, 0, 0, r, c, n};
        sb_q.push_back(e);
        n++;
        if (LimitOn && fs != 0 && n == fs) done = 1'b1;
      end
    end
    e = '{3, 0, 0, 0, 0, 0};
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t     e;
    logic [3:0] got, want;
    bit       ok;
    got = {ctrl_if.o_end_frame, ctrl_if.o_ctrl_data_run, ctrl_if.o_ctrl_hsync_run,
           ctrl_if.o_ctrl_vsync_run};
    if (got != 4'b0000) begin
      active_cycles++;
      if (ctrl_if.o_end_frame) end_pulses++;
      if (ctrl_if.o_ctrl_data_run) last_cnt = int'(ctrl_if.o_data_count);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_activity: got flags=%b, expected no active phase", got);
      end else begin
        e    = sb_q.pop_front();
        want = 4'b0001 << e.kind;
        ok   = (got == want);
        if (e.kind < 3) begin
          ok = ok && (ctrl_if.o_ctrl_vsync_cnt == e.vcnt) && (ctrl_if.o_ctrl_hsync_cnt == e.hcnt)
                  && (ctrl_if.o_row == e.row) && (ctrl_if.o_col == e.col)
                  && (ctrl_if.o_data_count == e.cnt);
        end
        if (!ok) begin
          errors++;
          $display("FAIL sb_cycle: got flags=%b v=%0d h=%0d row=%0d col=%0d cnt=%0d, expected flags=%b v=%0d h=%0d row=%0d col=%0d cnt=%0d",
                   got, ctrl_if.o_ctrl_vsync_cnt, ctrl_if.o_ctrl_hsync_cnt, ctrl_if.o_row,
                   ctrl_if.o_col, ctrl_if.o_data_count, want, e.vcnt, e.hcnt, e.row, e.col,
                   e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int unsigned w, input int unsigned h, input int unsigned v,
                         input int unsigned hs, input int unsigned fs);
    ctrl_if.q_width       = W_SIZE'(w);
    ctrl_if.q_height      = W_SIZE'(h);
    ctrl_if.q_vsync_delay = W_DELAY'(v);
    ctrl_if.q_hsync_delay = W_DELAY'(hs);
    ctrl_if.q_frame_size  = W_FRAME_SIZE'(fs);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, sb_q.size(), 0);
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (!ctrl_if.o_end_frame && n < budget) begin
      tick();
      n++;
    end
    check(name, ctrl_if.o_end_frame, 1);
  endtask

  task automatic start_latency(input string name);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (!ctrl_if.o_ctrl_vsync_run && lat < 10);
    check(name, lat, 2);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{4, 3, 2, 2, 0, 1, 21, 11};
    vecs[1] = '{1, 1, 0, 0, 0, 1, 2, 0};
    vecs[2] = '{128, 128, 200, 0, 16384, 5, 16585, 16383};
`ifdef CNN_CTRL_FRAME_LIMIT_EN
    vecs[3] = '{8, 8, 0, 0, 20, 1, 21, 19};
`else
    vecs[3] = '{8, 8, 0, 0, 20, 1, 65, 63};
`endif
    vecs[4] = '{3, 2, 0, 3, 0, 2, 13, 5};
    vecs[5] = '{5, 1, 1, 0, 0, 1, 7, 4};

    set_cfg(1, 1, 0, 0, 0);
    ctrl_if.q_start = 1'b0;
    repeat (3) tick();
    check_idle("reset_outputs");
    rstn = 1'b1;
    repeat (2) tick();
    check_idle("idle_after_release");

    for (int i = 0; i < 6; i++) begin
      set_cfg(vecs[i].w, vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].fs);
      active_cycles = 0;
      end_pulses    = 0;
      tick();
      ctrl_if.q_start = 1'b1;
      push_frame(vecs[i].w, vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].fs);
      repeat (vecs[i].hold) tick();
      ctrl_if.q_start = 1'b0;
      drain($sformatf("vec%0d_drain", i), int'(vecs[i].len) + 50);
      repeat (4) tick();
      check($sformatf("vec%0d_len", i), active_cycles, vecs[i].len);
      check($sformatf("vec%0d_end_pulses", i), end_pulses, 1);
      check($sformatf("vec%0d_last_count", i), last_cnt, vecs[i].last);
      check_idle($sformatf("vec%0d_idle_after", i));
    end

    // Start latency, and a second q_start edge mid-frame that must be ignored.
    set_cfg(2, 2, 3, 1, 0);
    active_cycles = 0;
    end_pulses    = 0;
    tick();
    ctrl_if.q_start = 1'b1;
    push_frame(2, 2, 3, 1, 0);
    start_latency("start_latency");
    n = 0;
    while (!ctrl_if.o_ctrl_data_run && n < 20) begin
      tick();
      n++;
    end
    ctrl_if.q_start = 1'b0;
    tick();
    ctrl_if.q_start = 1'b1;
    tick();
    ctrl_if.q_start = 1'b0;
    wait_end("retrig_frame_end", 30);
    // Edge sampled while in DONE is not accepted, and holding high does not retrigger.
    ctrl_if.q_start = 1'b1;
    repeat (3) tick();
    ctrl_if.q_start = 1'b0;
    repeat (4) tick();
    check("retrig_frame_len", active_cycles, 10);
    check("done_edge_ignored", end_pulses, 1);

    // Back-to-back: new edge in the first idle cycle after DONE.
    active_cycles = 0;
    end_pulses    = 0;
    ctrl_if.q_start = 1'b1;
    push_frame(2, 2, 3, 1, 0);
    tick();
    ctrl_if.q_start = 1'b0;
    wait_end("b2b_first_end", 30);
    tick();
    ctrl_if.q_start = 1'b1;
    push_frame(2, 2, 3, 1, 0);
    start_latency("restart_latency");
    ctrl_if.q_start = 1'b0;
    drain("b2b_drain", 40);
    repeat (3) tick();
    check("b2b_len", active_cycles, 20);
    check("b2b_end_pulses", end_pulses, 2);

    // Reset during DATA of row 1.
    set_cfg(4, 3, 2, 2, 0);
    active_cycles = 0;
    end_pulses    = 0;
    tick();
    ctrl_if.q_start = 1'b1;
    push_frame(4, 3, 2, 2, 0);
    tick();
    ctrl_if.q_start = 1'b0;
    n = 0;
    while (!(ctrl_if.o_ctrl_data_run && ctrl_if.o_row == 1) && n < 40) begin
      tick();
      n++;
    end
    check("reached_row1_data", ctrl_if.o_ctrl_data_run && ctrl_if.o_row == 1, 1);
    rstn = 1'b0;
    #1;
    sb_q.delete();
    check_idle("reset_mid_frame");
    active_cycles = 0;
    end_pulses    = 0;
    repeat (4) tick();
    rstn = 1'b1;
    repeat (8) tick();
    check("no_end_after_reset", end_pulses, 0);
    check("no_activity_after_reset", active_cycles, 0);
    check_idle("idle_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cnn_ctrl_fsm.md
# cnn_ctrl_fsm

Frame-timing controller for the CNN pixel pipeline. A start request launches one frame sequence: a vertical-sync delay, then for each image row a horizontal-sync delay followed by `q_width` data cycles. The block emits run flags, sync counters, row/column/linear pixel indices and an end-of-frame pulse that downstream line buffers, DMA and compute stages use to sequence their work.

## Interface
- `W_SIZE`, 12: width/height field width (max 4095).
- `W_FRAME_SIZE`, 2*W_SIZE+1: frame-size and pixel-count width.
- `W_DELAY`, 12: sync-delay field width.
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `q_width` in W_SIZE: pixels per row (≥1).
- `q_height` in W_SIZE: rows per frame (≥1).
- `q_vsync_delay` in W_DELAY: cycles of VSYNC per frame.
- `q_hsync_delay` in W_DELAY: cycles of HSYNC before each row.
- `q_frame_size` in W_FRAME_SIZE: pixel limit per frame.
- `q_start` in 1: start request, rising-edge sensitive.
- `o_ctrl_vsync_run` out 1: high in VSYNC.
- `o_ctrl_vsync_cnt` out W_DELAY: VSYNC cycle index.
- `o_ctrl_hsync_run` out 1: high in HSYNC.
- `o_ctrl_hsync_cnt` out W_DELAY: HSYNC cycle index.
- `o_ctrl_data_run` out 1: high in DATA (one pixel per cycle).
- `o_row` out W_SIZE: current row.
- `o_col` out W_SIZE: current column.
- `o_data_count` out W_FRAME_SIZE: linear pixel index in frame.
- `o_end_frame` out 1: one-cycle end-of-frame pulse.

## Operation
- States: IDLE, VSYNC, HSYNC, DATA, DONE. All outputs are registered. Reset drives IDLE, and every output resets to 0.
- The start trigger is `q_start`=1 while the registered previous `q_start`=0. A trigger is accepted only in IDLE; triggers in any other state are ignored. Holding `q_start` high does not retrigger.
- IDLE → VSYNC on trigger. VSYNC lasts `q_vsync_delay` cycles, with `o_ctrl_vsync_cnt` running 0..delay-1. If the delay is 0, VSYNC is skipped and the next state is HSYNC.
- HSYNC lasts `q_hsync_delay` cycles, with `o_ctrl_hsync_cnt` running 0..delay-1, then the block enters DATA. If the delay is 0, HSYNC is skipped and the next state is DATA directly.
- DATA issues `q_width` cycles. `o_col` runs 0..width-1. `o_data_count` increments every DATA cycle and equals row*width+col.
- At col==width-1:
  - If it is not the last pixel, `o_row`+1, `o_col`←0, next state HSYNC (or DATA if the hsync delay is 0).
  - The last pixel is row==height-1 (or the frame-limit condition below). After the last pixel the next state is DONE.
- DONE lasts exactly one cycle with `o_end_frame`=1, then IDLE. On entering IDLE, `o_row`, `o_col` and `o_data_count` clear to 0.
- Inputs are sampled continuously. Configuration must be held stable from trigger to `o_end_frame`; changes mid-frame are undefined.
- Asserting `rstn` low mid-frame immediately returns the block to IDLE with all outputs 0. No end pulse is produced.

## Timing
- Trigger at edge N: VSYNC is visible (run=1, cnt=0) after edge N+1.
- Frame length from the first VSYNC cycle to the `o_end_frame` cycle is V + H*ROWS + W*ROWS + 1 cycles, where ROWS = q_height.
- At most one run flag is high in any cycle. `o_end_frame` is never high together with a run flag.
- The earliest new trigger is accepted in the cycle after DONE.

## Configuration
- `CNN_CTRL_FRAME_LIMIT_EN` defined: the frame also ends after the DATA cycle where `o_data_count`==`q_frame_size`-1, whichever of the two end conditions comes first. `q_frame_size`=0 disables the limit.
- `CNN_CTRL_FRAME_LIMIT_EN` not defined: `q_frame_size` is ignored and the frame ends only on row/column.

## Structure
- Package `cnn_ctrl_pkg`: state enum (IDLE/VSYNC/HSYNC/DATA/DONE) and default width constants W_SIZE, W_DELAY, W_FRAME_SIZE.
- Sub-module `cnn_ctrl_counter`: parameterized up-counter with clear, enable and terminal-count flag. It is instantiated for the vsync, hsync, column and row counters. The linear pixel count and the FSM stay in the top level.

## Test plan
- 128×128, vsync 200, hsync 0, frame 16384; `q_start` held high 5 cycles → VSYNC 200 cycles, then 16384 contiguous DATA cycles, `o_data_count` 0..16383, single `o_end_frame` pulse, no retrigger.
- 4×3, vsync 2, hsync 2 → sequence V,V,(H,H,D×4)×3, DONE; `o_row` 0..2; total 21 cycles including DONE.
- vsync 0, hsync 0, 1×1 → trigger, one DATA cycle, DONE on the next cycle.
- Second `q_start` edge mid-frame → ignored, so the frame length is unchanged. A new edge after `o_end_frame` starts a second identical frame.
- Reset pulse during DATA of row 1 → all outputs 0 immediately, IDLE, no `o_end_frame`.
- `CNN_CTRL_FRAME_LIMIT_EN` with 8×8 and `q_frame_size`=20 → last DATA has `o_data_count`=19 (row 2, col 3), then `o_end_frame`. Without the macro, the frame runs all 64 pixels.
